// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative unsigned divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package iter_divider_pkg;

  // Default operand width and the iteration counter width (2^DIV_CNT_W > DIV_WIDTH).
  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = 5;

  // Controller states; the spare encoding 2'b11 falls back to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Quotient reported for a zero divisor.
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring shift-subtract iteration: produces one quotient bit.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module iter_divider_div_step
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_p;
  logic [WIDTH:0] w_dsr_inv;
  logic [WIDTH:0] w_trial;
  logic           w_borrow;

  // Shift {acc,q} left once; the partial remainder keeps the carried-out bit.
  assign w_p       = {i_acc, i_q[WIDTH-1]};
  // Subtract as an add of the inverted, zero-extended divisor with carry-in 1,
  // kept WIDTH+1 bits wide so the MSB is a true borrow flag.
  assign w_dsr_inv = ~{1'b0, i_dsr};
  assign w_trial   = w_p + w_dsr_inv + {{WIDTH{1'b0}}, 1'b1};
  assign w_borrow  = w_trial[WIDTH];

  // Restore mux: keep the shifted remainder when the subtract borrowed.
  always_comb begin
    o_acc = w_borrow ? w_p[WIDTH-1:0] : w_trial[WIDTH-1:0];
    o_q   = {i_q[WIDTH-2:0], ~w_borrow};
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle unsigned divider, restoring algorithm, one quotient bit per cycle.
// Latency: done 17 cycles after an accepted start (WIDTH=16); 1 cycle for a zero divisor.
// Backpressure: start is only accepted in IDLE/DONE; busy stays high for the whole RUN phase.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dsr;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  iter_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_dsr (r_dsr),
    .o_acc (w_acc_nxt),
    .o_q   (w_q_nxt)
  );

  // Controller: state, iteration counter, working registers and held results.
  // Working registers (acc/q/dsr) are separate from the visible results so a
  // running division never disturbs the last reported answer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_dsr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (i_start) begin
            if (i_divisor != '0) begin
              r_acc   <= '0;
              r_q     <= i_dividend;
              r_dsr   <= i_divisor;
              r_cnt   <= '0;
              r_dz    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end else begin
              // Zero divisor: answer immediately, no iterations.
              r_quot  <= WIDTH'(DIV0_QUOT);
              r_rem   <= i_dividend;
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            // Final iteration: publish the step outputs directly as results.
            r_quot  <= w_q_nxt;
            r_rem   <= w_acc_nxt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quot;
  assign o_remainder   = r_rem;
  assign o_div_by_zero = r_dz;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed cases plus random operands.
// Reference results come from plain integer / and %.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_iter_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;
  logic         o_div_by_zero;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  iter_divider #(.WIDTH(W), .CNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a start pulse for one cycle; returns at cycle 1 after acceptance.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    i_start    = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    @(negedge clk);
    i_start    = 1'b0;
  endtask

  // Wait (bounded) for done, counting cycles since start and busy cycles seen.
  task automatic wait_done(input int lat0, output int lat, output int busy_n);
    lat    = lat0;
    busy_n = 0;
    while (!o_done && lat < 60) begin
      if (o_busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Compare the done-cycle outputs with the arithmetic reference.
  task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat0);
    int lat, busy_n, exp_lat, exp_busy;
    logic [W-1:0] eq, er;
    logic edz;
    wait_done(lat0, lat, busy_n);
    if (b == 0) begin
      eq = 16'hFFFF; er = a; edz = 1'b1; exp_lat = 1; exp_busy = 0;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0; exp_lat = 17; exp_busy = 17 - lat0;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".busy_cycles"}, busy_n, exp_busy);
    chk({tag, ".done"}, {31'd0, o_done}, 1);
    chk({tag, ".quotient"}, {16'd0, o_quotient}, {16'd0, eq});
    chk({tag, ".remainder"}, {16'd0, o_remainder}, {16'd0, er});
    chk({tag, ".div_by_zero"}, {31'd0, o_div_by_zero}, {31'd0, edz});
    last_q = eq;
    last_r = er;
  endtask

  // One cycle after done without a new start: pulse gone, results held.
  task automatic check_hold(input string tag);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'd0, o_done}, 0);
    chk({tag, ".idle_busy"}, {31'd0, o_busy}, 0);
    chk({tag, ".hold_q"}, {16'd0, o_quotient}, {16'd0, last_q});
    chk({tag, ".hold_r"}, {16'd0, o_remainder}, {16'd0, last_r});
  endtask

  initial begin
    logic [W-1:0] a, b;
    int mode;
    rst = 1'b1; i_start = 1'b0; i_dividend = '0; i_divisor = '0;
    last_q = '0; last_r = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.busy", {31'd0, o_busy}, 0);
    chk("reset.done", {31'd0, o_done}, 0);
    chk("reset.quotient", {16'd0, o_quotient}, 0);
    chk("reset.remainder", {16'd0, o_remainder}, 0);
    chk("reset.div_by_zero", {31'd0, o_div_by_zero}, 0);

    start_op(16'd100, 16'd7);
    check_op("d100_7", 16'd100, 16'd7, 1);
    check_hold("d100_7");

    start_op(16'hFFFF, 16'h0001);
    check_op("dFFFF_1", 16'hFFFF, 16'h0001, 1);
    start_op(16'hFFFF, 16'hFFFF);
    check_op("dFFFF_FFFF", 16'hFFFF, 16'hFFFF, 1);

    start_op(16'd3, 16'd10);
    check_op("d3_10", 16'd3, 16'd10, 1);
    start_op(16'd0, 16'd5);
    check_op("d0_5", 16'd0, 16'd5, 1);
    check_hold("d0_5");

    start_op(16'd5, 16'd0);
    check_op("d5_0", 16'd5, 16'd0, 1);
    check_hold("d5_0");
    start_op(16'd9, 16'd3);
    check_op("d9_3", 16'd9, 16'd3, 1);

    // Start and operand changes while running must be ignored.
    start_op(16'd1000, 16'd9);
    repeat (4) @(negedge clk);
    chk("midrun.busy", {31'd0, o_busy}, 1);
    chk("midrun.hold_q", {16'd0, o_quotient}, {16'd0, last_q});
    i_start = 1'b1; i_dividend = 16'd8; i_divisor = 16'd2;
    @(negedge clk);
    i_start = 1'b0; i_dividend = 16'd123; i_divisor = 16'd45;
    check_op("d1000_9", 16'd1000, 16'd9, 6);
    // Back-to-back start in the done cycle.
    i_start = 1'b1; i_dividend = 16'd50; i_divisor = 16'd6;
    @(negedge clk);
    i_start = 1'b0;
    check_op("d50_6_b2b", 16'd50, 16'd6, 1);

    // Reset in the middle of a run discards it and clears every output.
    start_op(16'd40000, 16'd3);
    repeat (7) @(negedge clk);
    chk("rstmid.busy_before", {31'd0, o_busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.busy", {31'd0, o_busy}, 0);
    chk("rstmid.done", {31'd0, o_done}, 0);
    chk("rstmid.quotient", {16'd0, o_quotient}, 0);
    chk("rstmid.remainder", {16'd0, o_remainder}, 0);
    chk("rstmid.div_by_zero", {31'd0, o_div_by_zero}, 0);
    start_op(16'd40000, 16'd3);
    check_op("d40000_3", 16'd40000, 16'd3, 1);

    // Random operands, biased towards small, zero and equal divisors.
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      mode = int'($urandom_range(0, 3));
      case (mode)
        0:       b = W'($urandom_range(0, 3));
        1:       b = W'($urandom);
        2:       b = a;
        default: b = W'($urandom_range(1, 255));
      endcase
      start_op(a, b);
      check_op("random", a, b, 1);
      if ($urandom_range(0, 1) == 1) check_hold("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle unsigned 16-bit divider: restoring shift-subtract, one quotient bit per cycle.
- Companion to the adder datapath in the execute stage: the adder covers add and multiply paths, this block covers the inverse operation through repeated subtraction.
- Start/done handshake; the execute stage stalls the pipeline while busy is high.

Parameters:
- WIDTH, 16, operand, quotient and remainder width; also the number of iterations.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request. Sampled only in IDLE or DONE.
- dividend  in  WIDTH  unsigned numerator. Sampled on the accepted start.
- divisor  in  WIDTH  unsigned denominator. Sampled on the accepted start.
- busy  out  1  high while in state RUN.
- done  out  1  one-cycle pulse; results valid in that cycle and held afterwards.
- quotient  out  WIDTH  result quotient.
- remainder  out  WIDTH  result remainder.
- div_by_zero  out  1  high with done when divisor was 0; held with the results.

Behaviour:
- One clock domain. Reset is synchronous and active-high; name the ports clk and rst.
- Reset (including mid-operation) -> state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0. Any operation in flight is discarded.
- States: IDLE, RUN, DONE, held in a 2-bit state register. The unused encoding returns to IDLE.
- IDLE/DONE with start=1 and divisor!=0:
  - acc <= 0; q <= dividend; dsr <= divisor; cnt <= 0; div_by_zero <= 0.
  - Next state RUN.
- IDLE/DONE with start=1 and divisor==0:
  - quotient <= all ones; remainder <= dividend; div_by_zero <= 1.
  - Next state DONE, so done is high in the cycle after start.
- RUN, each cycle:
  - Shift {acc,q} left by 1 to form a WIDTH+1-bit partial remainder p.
  - trial = p - {0,dsr}, computed WIDTH+1 bits wide. No truncation before the borrow check.
  - If trial has no borrow (MSB=0): acc <= trial[WIDTH-1:0], new q LSB = 1.
  - Otherwise: acc <= p[WIDTH-1:0], new q LSB = 0.
  - cnt increments each RUN cycle. On the cycle where cnt==WIDTH-1, the next state is DONE.
- Latency with a nonzero divisor: start is sampled at edge E0. done is high in the cycle following E16, i.e. 17 cycles after the start cycle. busy is high for exactly 16 cycles.
- DONE:
  - done=1 for exactly that cycle.
  - quotient=q, remainder=acc.
  - Without start, next state IDLE.
  - With start, back-to-back acceptance as defined for IDLE.
- Result retention: quotient, remainder and div_by_zero hold their values in IDLE until the next completion or reset. RUN must not disturb the visible outputs; use separate working registers.
- start during RUN is ignored, and operand changes during RUN have no effect.
- Boundary results:
  - dividend<divisor gives q=0, r=dividend.
  - divisor=1 gives q=dividend, r=0.
  - dividend=0 with nonzero divisor gives q=0, r=0 after full latency. There is no early exit.
- Arithmetic is purely unsigned. Signed division is handled by the caller through operand and result negation.

Decomposition:
- Shared package/include: WIDTH default, the state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10, and the all-ones constant used for divide-by-zero.
- One sub-module, div_step, is combinational:
  - Inputs: acc, q, dsr.
  - Outputs: next acc, next q.
  - Contains the shift, the WIDTH+1-bit subtract (built from the team's adder with inverted divisor and carry-in 1) and the restore mux.
- The top level holds the FSM, counter, working registers and result registers.

Test Plan:
- Reset, then start with 100/7 -> busy for 16 cycles; done pulse 17 cycles after start; quotient=14, remainder=2, div_by_zero=0.
- 16'hFFFF/16'h0001, then 16'hFFFF/16'hFFFF -> quotient=16'hFFFF with remainder=0, then quotient=1 with remainder=0.
- 3/10, then 0/5 -> quotient=0 with remainder=3, then quotient=0 with remainder=0, each after the full 17 cycles.
- 5/0 -> done one cycle after start; quotient=16'hFFFF, remainder=5, div_by_zero=1. A following 9/3 clears the flag and gives quotient=3.
- 1000/9 started; at cycle 5 of RUN pulse start with 8/2 and change the operands -> ignored; result quotient=111, remainder=1. Assert start in the done cycle with 50/6 -> accepted back-to-back; quotient=8, remainder=2.
- 40000/3 started; assert rst at RUN cycle 8 -> next cycle all outputs 0 and state IDLE. A subsequent 40000/3 gives quotient=13333, remainder=1.
